// File: rtl/bus_arbiter_rr.sv
// Registered N-way bus arbiter: fixed-priority or round-robin selection, grant
// held until release, one idle cycle between owners, optional tenure timeout.
module bus_arbiter_rr #(
  parameter int N        = 4,
  parameter int MODE     = 1,
  parameter int MAX_HOLD = 0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N-1:0]           BR,
  output logic [N-1:0]           BG,
  output logic [$clog2(N)-1:0]   GNT_ID,
  output logic                   BUSY,
  output logic                   TIMEOUT
);

  localparam int IW = $clog2(N);
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    bg_q, bg_d;
  logic [IW-1:0]   gnt_id_q, gnt_id_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    mask_q, mask_d;
  logic [IW-1:0]   last_q, last_d;

  logic [N-1:0]    req_s;
  logic [IW-1:0]   win_idx_s;
  logic            owner_br_s;

  // Winner selection over the unmasked requests.
  always_comb begin
    int s;
    req_s     = BR & ~mask_q;
    win_idx_s = '0;
    s         = 0;
    if (MODE == 0) begin
      // Ascending scan: the highest set index overwrites lower ones.
      for (int i = 0; i < N; i++) begin
        win_idx_s = req_s[i] ? IW'(i) : win_idx_s;
      end
    end else begin
      // Descending distance scan: the nearest requester above last wins.
      for (int k = N; k >= 1; k--) begin
        s         = int'(last_q) + k;
        s         = (s >= N) ? (s - N) : s;
        win_idx_s = req_s[IW'(s)] ? IW'(s) : win_idx_s;
      end
    end
  end

  assign owner_br_s = BR[gnt_id_q];

  // Next-state, grant, counter and revoke-mask computation.
  always_comb begin
    state_d   = state_q;
    bg_d      = bg_q;
    gnt_id_d  = gnt_id_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    last_d    = last_q;
    mask_d    = mask_q & BR;
    case (state_q)
      ST_IDLE: begin
        if (|req_s) begin
          state_d  = ST_GRANT;
          bg_d     = {{(N-1){1'b0}}, 1'b1} << win_idx_s;
          gnt_id_d = win_idx_s;
          busy_d   = 1'b1;
          cnt_d    = '0;
          last_d   = win_idx_s;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!owner_br_s) begin
          state_d  = ST_IDLE;
          bg_d     = '0;
          gnt_id_d = '0;
          busy_d   = 1'b0;
        end else if ((MAX_HOLD > 0) && (cnt_q == HOLD_LAST)) begin
          state_d           = ST_IDLE;
          bg_d              = '0;
          gnt_id_d          = '0;
          busy_d            = 1'b0;
          timeout_d         = 1'b1;
          mask_d[gnt_id_q]  = 1'b1;
        end else begin
          cnt_d = (MAX_HOLD > 0) ? (cnt_q + CW'(1)) : cnt_q;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        bg_d     = '0;
        gnt_id_d = '0;
        busy_d   = 1'b0;
        cnt_d    = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      bg_q      <= '0;
      gnt_id_q  <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      mask_q    <= '0;
      last_q    <= IW'(N - 1);
    end else begin
      state_q   <= state_d;
      bg_q      <= bg_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      last_q    <= last_d;
    end
  end

  assign BG      = bg_q;
  assign GNT_ID  = gnt_id_q;
  assign BUSY    = busy_q;
  assign TIMEOUT = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: several parameterisations share one clock,
// each scenario task checks hand-computed grant sequences.
module tb_bus_arbiter_rr;

  logic clk;
  logic rst;

  logic [3:0] br_fp, bg_fp; logic [1:0] id_fp; logic busy_fp, to_fp;
  logic [3:0] br_rr, bg_rr; logic [1:0] id_rr; logic busy_rr, to_rr;
  logic [3:0] br_to, bg_to; logic [1:0] id_to; logic busy_to, to_to;
  logic [3:0] br_h1, bg_h1; logic [1:0] id_h1; logic busy_h1, to_h1;
  logic [4:0] br_w5, bg_w5; logic [2:0] id_w5; logic busy_w5, to_w5;

  int n_tests = 0;
  int n_fail  = 0;

  bus_arbiter_rr #(.N(4), .MODE(0), .MAX_HOLD(0)) u_fp (
    .CLK(clk), .RST(rst), .BR(br_fp), .BG(bg_fp), .GNT_ID(id_fp), .BUSY(busy_fp), .TIMEOUT(to_fp));
  bus_arbiter_rr #(.N(4), .MODE(1), .MAX_HOLD(0)) u_rr (
    .CLK(clk), .RST(rst), .BR(br_rr), .BG(bg_rr), .GNT_ID(id_rr), .BUSY(busy_rr), .TIMEOUT(to_rr));
  bus_arbiter_rr #(.N(4), .MODE(0), .MAX_HOLD(3)) u_to (
    .CLK(clk), .RST(rst), .BR(br_to), .BG(bg_to), .GNT_ID(id_to), .BUSY(busy_to), .TIMEOUT(to_to));
  bus_arbiter_rr #(.N(4), .MODE(1), .MAX_HOLD(1)) u_h1 (
    .CLK(clk), .RST(rst), .BR(br_h1), .BG(bg_h1), .GNT_ID(id_h1), .BUSY(busy_h1), .TIMEOUT(to_h1));
  bus_arbiter_rr #(.N(5), .MODE(1), .MAX_HOLD(0)) u_w5 (
    .CLK(clk), .RST(rst), .BR(br_w5), .BG(bg_w5), .GNT_ID(id_w5), .BUSY(busy_w5), .TIMEOUT(to_w5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    br_fp = 4'b0; br_rr = 4'b0; br_to = 4'b0; br_h1 = 4'b0; br_w5 = 5'b0;
    tick(); tick();
    n_tests++; if (bg_fp !== 4'b0000 || busy_fp !== 1'b0 || id_fp !== 2'd0 || to_fp !== 1'b0) begin n_fail++; $display("FAIL reset_fp: BG=%b BUSY=%b ID=%0d TO=%b expected all 0", bg_fp, busy_fp, id_fp, to_fp); end
    n_tests++; if (bg_rr !== 4'b0000 || busy_rr !== 1'b0 || id_rr !== 2'd0 || to_rr !== 1'b0) begin n_fail++; $display("FAIL reset_rr: BG=%b BUSY=%b ID=%0d TO=%b expected all 0", bg_rr, busy_rr, id_rr, to_rr); end
    n_tests++; if (bg_to !== 4'b0000 || busy_to !== 1'b0 || id_to !== 2'd0 || to_to !== 1'b0) begin n_fail++; $display("FAIL reset_to: BG=%b BUSY=%b ID=%0d TO=%b expected all 0", bg_to, busy_to, id_to, to_to); end
    n_tests++; if (bg_w5 !== 5'b00000 || busy_w5 !== 1'b0 || id_w5 !== 3'd0 || to_w5 !== 1'b0) begin n_fail++; $display("FAIL reset_w5: BG=%b BUSY=%b ID=%0d TO=%b expected all 0", bg_w5, busy_w5, id_w5, to_w5); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fixed_priority();
    br_fp = 4'b0110;
    tick();
    n_tests++; if (bg_fp !== 4'b0100 || id_fp !== 2'd2 || busy_fp !== 1'b1) begin n_fail++; $display("FAIL fp_first: BG=%b ID=%0d BUSY=%b expected 0100/2/1", bg_fp, id_fp, busy_fp); end
    tick();
    n_tests++; if (bg_fp !== 4'b0100) begin n_fail++; $display("FAIL fp_hold: BG=%b expected 0100", bg_fp); end
    br_fp = 4'b0010;
    tick();
    n_tests++; if (bg_fp !== 4'b0000 || busy_fp !== 1'b0 || id_fp !== 2'd0) begin n_fail++; $display("FAIL fp_gap: BG=%b BUSY=%b ID=%0d expected 0000/0/0", bg_fp, busy_fp, id_fp); end
    tick();
    n_tests++; if (bg_fp !== 4'b0010 || id_fp !== 2'd1) begin n_fail++; $display("FAIL fp_second: BG=%b ID=%0d expected 0010/1", bg_fp, id_fp); end
    br_fp = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_round_robin();
    br_rr = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int w;
      logic [3:0] ex;
      w  = k % 4;
      ex = 4'b0001 << w;
      tick();
      n_tests++; if (bg_rr !== ex || id_rr !== 2'(w) || busy_rr !== 1'b1) begin n_fail++; $display("FAIL rr_grant[%0d]: BG=%b ID=%0d expected %b/%0d", k, bg_rr, id_rr, ex, w); end
      tick();
      n_tests++; if (bg_rr !== ex) begin n_fail++; $display("FAIL rr_hold[%0d]: BG=%b expected %b", k, bg_rr, ex); end
      br_rr[w] = 1'b0;
      tick();
      n_tests++; if (bg_rr !== 4'b0000 || busy_rr !== 1'b0) begin n_fail++; $display("FAIL rr_gap[%0d]: BG=%b BUSY=%b expected 0000/0", k, bg_rr, busy_rr); end
      br_rr = 4'b1111;
    end
    br_rr = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_timeout();
    br_to = 4'b1001;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++; if (bg_to !== 4'b1000 || to_to !== 1'b0) begin n_fail++; $display("FAIL to_tenure[%0d]: BG=%b TO=%b expected 1000/0", c, bg_to, to_to); end
    end
    tick();
    n_tests++; if (bg_to !== 4'b0000 || to_to !== 1'b1 || busy_to !== 1'b0) begin n_fail++; $display("FAIL to_revoke: BG=%b TO=%b BUSY=%b expected 0000/1/0", bg_to, to_to, busy_to); end
    tick();
    n_tests++; if (bg_to !== 4'b0001 || to_to !== 1'b0 || id_to !== 2'd0) begin n_fail++; $display("FAIL to_masked: BG=%b TO=%b ID=%0d expected 0001/0/0", bg_to, to_to, id_to); end
    br_to = 4'b0001;
    tick();
    br_to = 4'b1001;
    tick();
    n_tests++; if (bg_to !== 4'b0001) begin n_fail++; $display("FAIL to_no_preempt: BG=%b expected 0001", bg_to); end
    br_to = 4'b1000;
    tick();
    n_tests++; if (bg_to !== 4'b0000 || to_to !== 1'b0) begin n_fail++; $display("FAIL to_release0: BG=%b TO=%b expected 0000/0", bg_to, to_to); end
    tick();
    n_tests++; if (bg_to !== 4'b1000 || id_to !== 2'd3) begin n_fail++; $display("FAIL to_unmasked: BG=%b ID=%0d expected 1000/3", bg_to, id_to); end
    br_to = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_release_on_timeout_edge();
    br_to = 4'b0100;
    tick(); tick(); tick();
    n_tests++; if (bg_to !== 4'b0100) begin n_fail++; $display("FAIL rte_third: BG=%b expected 0100", bg_to); end
    br_to = 4'b0000;
    tick();
    n_tests++; if (bg_to !== 4'b0000 || to_to !== 1'b0) begin n_fail++; $display("FAIL rte_release: BG=%b TO=%b expected 0000/0", bg_to, to_to); end
    br_to = 4'b0100;
    tick();
    n_tests++; if (bg_to !== 4'b0100 || to_to !== 1'b0) begin n_fail++; $display("FAIL rte_regrant: BG=%b TO=%b expected 0100/0", bg_to, to_to); end
    br_to = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_hold_one();
    br_h1 = 4'b0011;
    tick();
    n_tests++; if (bg_h1 !== 4'b0001) begin n_fail++; $display("FAIL h1_g0: BG=%b expected 0001", bg_h1); end
    tick();
    n_tests++; if (bg_h1 !== 4'b0000 || to_h1 !== 1'b1) begin n_fail++; $display("FAIL h1_to0: BG=%b TO=%b expected 0000/1", bg_h1, to_h1); end
    tick();
    n_tests++; if (bg_h1 !== 4'b0010 || to_h1 !== 1'b0) begin n_fail++; $display("FAIL h1_g1: BG=%b TO=%b expected 0010/0", bg_h1, to_h1); end
    tick();
    n_tests++; if (bg_h1 !== 4'b0000 || to_h1 !== 1'b1) begin n_fail++; $display("FAIL h1_to1: BG=%b TO=%b expected 0000/1", bg_h1, to_h1); end
    tick();
    n_tests++; if (bg_h1 !== 4'b0000 || to_h1 !== 1'b0) begin n_fail++; $display("FAIL h1_masked: BG=%b TO=%b expected 0000/0", bg_h1, to_h1); end
    br_h1 = 4'b0000;
    tick();
    br_h1 = 4'b0001;
    tick();
    n_tests++; if (bg_h1 !== 4'b0001) begin n_fail++; $display("FAIL h1_regrant: BG=%b expected 0001", bg_h1); end
    br_h1 = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_async_reset();
    br_rr = 4'b0100;
    tick();
    n_tests++; if (bg_rr !== 4'b0100) begin n_fail++; $display("FAIL ar_pre: BG=%b expected 0100", bg_rr); end
    #3;
    rst = 1'b1;
    #1;
    n_tests++; if (bg_rr !== 4'b0000 || busy_rr !== 1'b0 || id_rr !== 2'd0) begin n_fail++; $display("FAIL ar_immediate: BG=%b BUSY=%b ID=%0d expected 0000/0/0", bg_rr, busy_rr, id_rr); end
    br_rr = 4'b1111;
    tick();
    rst = 1'b0;
    tick();
    n_tests++; if (bg_rr !== 4'b0001 || id_rr !== 2'd0) begin n_fail++; $display("FAIL ar_first: BG=%b ID=%0d expected 0001/0", bg_rr, id_rr); end
    br_rr = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_wrap_and_width();
    logic [4:0] prev;
    br_w5 = 5'b10000;
    tick();
    n_tests++; if (bg_w5 !== 5'b10000 || id_w5 !== 3'd4) begin n_fail++; $display("FAIL w5_g4: BG=%b ID=%0d expected 10000/4", bg_w5, id_w5); end
    br_w5 = 5'b00000;
    tick();
    br_w5 = 5'b10001;
    tick();
    n_tests++; if (bg_w5 !== 5'b00001 || id_w5 !== 3'd0) begin n_fail++; $display("FAIL w5_wrap: BG=%b ID=%0d expected 00001/0", bg_w5, id_w5); end
    br_w5 = 5'b10000;
    tick();
    n_tests++; if (bg_w5 !== 5'b00000) begin n_fail++; $display("FAIL w5_gap: BG=%b expected 00000", bg_w5); end
    tick();
    n_tests++; if (bg_w5 !== 5'b10000 || id_w5 !== 3'd4) begin n_fail++; $display("FAIL w5_next: BG=%b ID=%0d expected 10000/4", bg_w5, id_w5); end
    for (int i = 0; i < 10000; i++) begin
      br_w5 = 5'($urandom_range(0, 31));
      prev  = br_w5;
      tick();
      n_tests++;
      if (!$onehot0(bg_w5) || ((bg_w5 & ~prev) !== 5'b00000) || (busy_w5 !== (|bg_w5))) begin
        n_fail++;
        $display("FAIL w5_random[%0d]: BG=%b BR=%b BUSY=%b expected one-hot-or-zero grant within BR", i, bg_w5, prev, busy_w5);
      end
    end
    br_w5 = 5'b00000;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_timeout();
    test_release_on_timeout_edge();
    test_hold_one();
    test_async_reset();
    test_wrap_and_width();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
